// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, datapath mux codes, opcodes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [1:0] PcSelPlus4  = 2'd0;
    localparam logic [1:0] PcSelPcImm  = 2'd1;
    localparam logic [1:0] PcSelAluLsb = 2'd2;
    localparam logic [1:0] PcSelTrap   = 2'd3;

    localparam logic [1:0] AluASelRs1  = 2'd0;
    localparam logic [1:0] AluASelPc   = 2'd1;
    localparam logic [1:0] AluASelZero = 2'd2;

    localparam logic       AluBSelRs2  = 1'b0;
    localparam logic       AluBSelImm  = 1'b1;

    localparam logic [1:0] WbSelAlu    = 2'd0;
    localparam logic [1:0] WbSelLoad   = 2'd1;
    localparam logic [1:0] WbSelPc4    = 2'd2;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLd     = 7'b0000011;
    localparam logic [6:0] OpS      = 7'b0100011;
    localparam logic [6:0] OpB      = 7'b1100011;
    localparam logic [6:0] OpJ      = 7'b1101111;
    localparam logic [6:0] OpJr     = 7'b1100111;
    localparam logic [6:0] OpU      = 7'b0110111;
    localparam logic [6:0] OpUpc    = 7'b0010111;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // One bit per instruction class; at most one is set.
    typedef struct packed {
        logic r;
        logic i;
        logic ld;
        logic s;
        logic b;
        logic j;
        logic jr;
        logic u;
        logic upc;
        logic fence;
        logic sys;
    } op_class_t;

    function automatic logic [1:0] alu_a_sel(input op_class_t c);
        if (c.u)              return AluASelZero;
        if (c.upc || c.j)     return AluASelPc;
        return AluASelRs1;
    endfunction

    function automatic logic alu_b_sel(input op_class_t c);
        return (c.r || c.b) ? AluBSelRs2 : AluBSelImm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opdec.sv
// Combinational opcode classifier: one-hot instruction class plus a legal flag.
module multicycle_ctrl_opdec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       legal
);

    always_comb begin
        op_class       = '0;
        op_class.r     = (opcode == OpR);
        op_class.i     = (opcode == OpI);
        op_class.ld    = (opcode == OpLd);
        op_class.s     = (opcode == OpS);
        op_class.b     = (opcode == OpB);
        op_class.j     = (opcode == OpJ);
        op_class.jr    = (opcode == OpJr);
        op_class.u     = (opcode == OpU);
        op_class.upc   = (opcode == OpUpc);
        op_class.fence = (opcode == OpFence);
        op_class.sys   = (opcode == OpSystem);
        legal          = |op_class;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB(/TRAP) over a shared datapath.
// Define ILLEGAL_TRAP_EN to route illegal opcodes to a one-cycle TRAP state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned RD_ZERO_GUARD = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    input  logic        i_br_taken,
    output logic        o_imem_req,
    output logic        o_ir_we,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_pc_we,
    output logic [1:0]  o_pc_sel,
    output logic [1:0]  o_alu_a_sel,
    output logic        o_alu_b_sel,
    output logic        o_reg_we,
    output logic [1:0]  o_wb_sel,
    output logic        o_retire,
    output logic        o_trap,
    output logic [2:0]  o_state
);

    op_class_t cls;
    logic      legal;
    state_e    state_q;
    logic      to_mem;
    logic      to_wb;
    logic      rd_is_zero;
    logic      unused_sig;

    multicycle_ctrl_opdec u_opdec (
        .opcode   (i_instr[6:0]),
        .op_class (cls),
        .legal    (legal)
    );

    assign to_mem     = cls.ld || cls.s;
    assign to_wb      = cls.r || cls.i || cls.u || cls.upc || cls.j || cls.jr;
    assign rd_is_zero = (i_instr[11:7] == 5'd0);
    assign unused_sig = ^{i_instr[31:12], legal, cls.fence, cls.sys};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:  if (i_imem_ack) state_q <= StDecode;
`ifdef ILLEGAL_TRAP_EN
                StDecode: state_q <= legal ? StExec : StTrap;
`else
                StDecode: state_q <= StExec;
`endif
                StExec: begin
                    if (to_mem)     state_q <= StMem;
                    else if (to_wb) state_q <= StWb;
                    else            state_q <= StFetch;
                end
                StMem:    if (i_dmem_ack) state_q <= cls.ld ? StWb : StFetch;
                default:  state_q <= StFetch;
            endcase
        end
    end

    // Reset forces every output low in the same cycle, so held requests drop immediately.
    always_comb begin
        o_imem_req  = 1'b0;
        o_ir_we     = 1'b0;
        o_dmem_req  = 1'b0;
        o_dmem_we   = 1'b0;
        o_pc_we     = 1'b0;
        o_pc_sel    = PcSelPlus4;
        o_alu_a_sel = AluASelRs1;
        o_alu_b_sel = AluBSelRs2;
        o_reg_we    = 1'b0;
        o_wb_sel    = WbSelAlu;
        o_retire    = 1'b0;
        o_trap      = 1'b0;
        o_state     = 3'd0;
        if (!i_rst) begin
            o_state = state_q;
            case (state_q)
                StFetch: begin
                    o_imem_req = 1'b1;
                    o_ir_we    = i_imem_ack;
                end
                StExec: begin
                    o_alu_a_sel = alu_a_sel(cls);
                    o_alu_b_sel = alu_b_sel(cls);
                    if (cls.b) begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = i_br_taken ? PcSelPcImm : PcSelPlus4;
                        o_retire = 1'b1;
                    end else if (!to_mem && !to_wb) begin
                        o_pc_we  = 1'b1;
                        o_retire = 1'b1;
                    end
                end
                StMem: begin
                    o_alu_a_sel = alu_a_sel(cls);
                    o_alu_b_sel = alu_b_sel(cls);
                    o_dmem_req  = 1'b1;
                    o_dmem_we   = cls.s;
                    if (i_dmem_ack && cls.s) begin
                        o_pc_we  = 1'b1;
                        o_retire = 1'b1;
                    end
                end
                StWb: begin
                    o_alu_a_sel = alu_a_sel(cls);
                    o_alu_b_sel = alu_b_sel(cls);
                    o_reg_we    = !((RD_ZERO_GUARD != 0) && rd_is_zero);
                    o_pc_we     = 1'b1;
                    o_retire    = 1'b1;
                    if (cls.ld)                  o_wb_sel = WbSelLoad;
                    else if (cls.j || cls.jr)    o_wb_sel = WbSelPc4;
                    if (cls.j)                   o_pc_sel = PcSelPcImm;
                    else if (cls.jr)             o_pc_sel = PcSelAluLsb;
                end
`ifdef ILLEGAL_TRAP_EN
                StTrap: begin
                    o_trap   = 1'b1;
                    o_pc_we  = 1'b1;
                    o_pc_sel = PcSelTrap;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_instr;
    logic        i_imem_ack, i_dmem_ack, i_br_taken;
    logic        o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_pc_we;
    logic [1:0]  o_pc_sel, o_alu_a_sel, o_wb_sel;
    logic        o_alu_b_sel, o_reg_we, o_retire, o_trap;
    logic [2:0]  o_state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.RD_ZERO_GUARD(1)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_instr     (i_instr),
        .i_imem_ack  (i_imem_ack),
        .i_dmem_ack  (i_dmem_ack),
        .i_br_taken  (i_br_taken),
        .o_imem_req  (o_imem_req),
        .o_ir_we     (o_ir_we),
        .o_dmem_req  (o_dmem_req),
        .o_dmem_we   (o_dmem_we),
        .o_pc_we     (o_pc_we),
        .o_pc_sel    (o_pc_sel),
        .o_alu_a_sel (o_alu_a_sel),
        .o_alu_b_sel (o_alu_b_sel),
        .o_reg_we    (o_reg_we),
        .o_wb_sel    (o_wb_sel),
        .o_retire    (o_retire),
        .o_trap      (o_trap),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Fetch with an immediate ack, pass DECODE, land one tick past the edge into the next state.
    task automatic fetch_decode(input logic [31:0] instr);
        i_instr    = instr;
        i_imem_ack = 1'b1;
        #1;
        check_eq("fetch_state", o_state, 0);
        check_eq("fetch_ir_we", o_ir_we, 1);
        cyc();
        i_imem_ack = 1'b0;
        #1;
        check_eq("decode_state", o_state, 1);
        check_eq("decode_pc_we", o_pc_we, 0);
        cyc();
    endtask

    initial begin
        i_rst = 1'b1; i_instr = '0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0; i_br_taken = 1'b0;
        cyc(); cyc();
        check_eq("rst_imem_req", o_imem_req, 0);
        check_eq("rst_state", o_state, 0);
        i_rst = 1'b0;
        #1;
        check_eq("first_imem_req", o_imem_req, 1);

        // Fetch wait: no ack for one cycle keeps the request up without loading the IR.
        #1;
        check_eq("fwait_req", o_imem_req, 1);
        check_eq("fwait_ir_we", o_ir_we, 0);
        cyc();

        // ADDI x1,x0,5
        fetch_decode(32'h00500093);
        #1;
        check_eq("addi_exec_state", o_state, 2);
        check_eq("addi_alu_a", o_alu_a_sel, 0);
        check_eq("addi_alu_b", o_alu_b_sel, 1);
        check_eq("addi_exec_retire", o_retire, 0);
        cyc(); #1;
        check_eq("addi_wb_state", o_state, 4);
        check_eq("addi_reg_we", o_reg_we, 1);
        check_eq("addi_wb_sel", o_wb_sel, 0);
        check_eq("addi_pc_sel", o_pc_sel, 0);
        check_eq("addi_pc_we", o_pc_we, 1);
        check_eq("addi_retire", o_retire, 1);
        cyc(); #1;
        check_eq("addi_back_fetch", o_state, 0);

        // LW x2,0(x1) with three dmem wait cycles
        fetch_decode(32'h0000A103);
        #1;
        check_eq("lw_exec_state", o_state, 2);
        cyc();
        for (int k = 0; k < 4; k++) begin
            i_dmem_ack = (k == 3);
            #1;
            check_eq("lw_mem_state", o_state, 3);
            check_eq("lw_dmem_req", o_dmem_req, 1);
            check_eq("lw_dmem_we", o_dmem_we, 0);
            check_eq("lw_mem_retire", o_retire, 0);
            cyc();
        end
        i_dmem_ack = 1'b0;
        #1;
        check_eq("lw_wb_state", o_state, 4);
        check_eq("lw_wb_sel", o_wb_sel, 1);
        check_eq("lw_reg_we", o_reg_we, 1);
        check_eq("lw_retire", o_retire, 1);
        cyc(); #1;
        check_eq("lw_back_fetch", o_state, 0);

        // SW x2,0(x1) with immediate ack
        fetch_decode(32'h0020A023);
        cyc();
        i_dmem_ack = 1'b1;
        #1;
        check_eq("sw_mem_state", o_state, 3);
        check_eq("sw_dmem_we", o_dmem_we, 1);
        check_eq("sw_pc_we", o_pc_we, 1);
        check_eq("sw_retire", o_retire, 1);
        check_eq("sw_reg_we", o_reg_we, 0);
        cyc();
        i_dmem_ack = 1'b0;
        #1;
        check_eq("sw_back_fetch", o_state, 0);

        // BEQ taken, then not taken
        for (int t = 1; t >= 0; t--) begin
            fetch_decode(32'h00000463);
            i_br_taken = t[0];
            #1;
            check_eq("beq_exec_state", o_state, 2);
            check_eq("beq_pc_we", o_pc_we, 1);
            check_eq("beq_pc_sel", o_pc_sel, t);
            check_eq("beq_retire", o_retire, 1);
            check_eq("beq_reg_we", o_reg_we, 0);
            check_eq("beq_alu_b", o_alu_b_sel, 0);
            cyc();
            i_br_taken = 1'b0;
            #1;
            check_eq("beq_back_fetch", o_state, 0);
        end

        // LUI x3,1: operand A is zero
        fetch_decode(32'h000011B7);
        #1;
        check_eq("lui_alu_a", o_alu_a_sel, 2);
        cyc(); cyc();

        // JALR x1,0(x2)
        fetch_decode(32'h000100E7);
        cyc(); #1;
        check_eq("jalr_wb_state", o_state, 4);
        check_eq("jalr_wb_sel", o_wb_sel, 2);
        check_eq("jalr_pc_sel", o_pc_sel, 2);
        check_eq("jalr_reg_we", o_reg_we, 1);
        cyc();

        // ADDI x0,x0,1: write to x0 suppressed
        fetch_decode(32'h00100013);
        cyc(); #1;
        check_eq("x0_wb_state", o_state, 4);
        check_eq("x0_reg_we", o_reg_we, 0);
        check_eq("x0_pc_we", o_pc_we, 1);
        check_eq("x0_retire", o_retire, 1);
        cyc();

        // Reset while MEM holds dmem_req
        fetch_decode(32'h0000A103);
        cyc(); #1;
        check_eq("rstmem_req_before", o_dmem_req, 1);
        i_rst = 1'b1;
        #1;
        check_eq("rstmem_req", o_dmem_req, 0);
        check_eq("rstmem_pc_we", o_pc_we, 0);
        check_eq("rstmem_reg_we", o_reg_we, 0);
        check_eq("rstmem_retire", o_retire, 0);
        cyc();
        i_rst = 1'b0;
        #1;
        check_eq("rstmem_state", o_state, 0);
        check_eq("rstmem_imem_req", o_imem_req, 1);

        // Illegal opcode
        fetch_decode(32'hFFFFFFFF);
        #1;
`ifdef ILLEGAL_TRAP_EN
        check_eq("ill_state", o_state, 5);
        check_eq("ill_trap", o_trap, 1);
        check_eq("ill_pc_sel", o_pc_sel, 3);
        check_eq("ill_pc_we", o_pc_we, 1);
        check_eq("ill_retire", o_retire, 0);
`else
        check_eq("ill_state", o_state, 2);
        check_eq("ill_trap", o_trap, 0);
        check_eq("ill_pc_sel", o_pc_sel, 0);
        check_eq("ill_pc_we", o_pc_we, 1);
        check_eq("ill_retire", o_retire, 1);
`endif
        cyc(); #1;
        check_eq("ill_back_fetch", o_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
